i2s_tx_stereo: RTL and testbench



---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_tx_stereo_if.sv | 18 +
 rtl/i2s_tx_stereo_sync_fifo.sv | 67 ++++++
 rtl/i2s_tx_stereo.sv | 161 ++++++++++++++++
 tb/tb_i2s_tx_stereo.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S / left-justified stereo transmitter.
//   FMT_I2S / FMT_LJ : encodings of the runtime format select input
//   fifo_lvl_w()     : width of a FIFO occupancy count (0..depth inclusive)
package i2s_pkg;

  localparam logic FMT_I2S = 1'b0;  // data delayed one BCK after LRCK edge
  localparam logic FMT_LJ  = 1'b1;  // data MSB aligned with LRCK edge

  // Occupancy must represent the value "depth" itself, hence the +1.
  function automatic int fifo_lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/i2s_tx_stereo_if.sv
// Sample input bus for i2s_tx_stereo.
//   in_valid : producer offers a stereo pair this cycle
//   in_ready : consumer can accept a pair this cycle
//   in_left / in_right : two's complement samples, DATA_W bits each
// Handshake: a pair is transferred on every clk edge where in_valid and
// in_ready are both 1. in_ready never depends on in_valid; the producer
// holds in_left/in_right stable while in_valid is high and not accepted.
interface i2s_tx_stereo_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/i2s_tx_stereo_sync_fifo.sv
// Single-clock FIFO with registered occupancy.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push/wdata : write request; ignored when full
//   pop/rdata  : read request; rdata shows the head entry; ignored when empty
//   full/empty/level : status, all derived from registered state only
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; resetting the pointers discards its contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S / left-justified serial transmitter, single clock domain.
//   clk, reset      : codec master clock, synchronous active-high reset
//   en              : 1 runs the serial interface, 0 idles it (FIFO kept)
//   fmt             : FMT_I2S or FMT_LJ, latched at each frame load
//   clr_underflow   : clears the sticky underflow flag
//   in_if           : valid/ready stereo sample input (slave side)
//   AUD_BCK/AUD_LRCK/AUD_DATA : serial outputs; LRCK 0 = left slot
//   frame_start     : one-cycle pulse on the cycle a frame is loaded
//   underflow       : sticky, a frame was loaded with the FIFO empty
//   fifo_level      : stereo pairs currently buffered
// BCK and LRCK are ordinary registered outputs toggled by clock-enable
// counters; no logic runs on them as clocks.
module i2s_tx_stereo
  import i2s_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 16,
  parameter int BCK_HALF   = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                en,
  input  logic                                fmt,
  input  logic                                clr_underflow,
  i2s_tx_stereo_if.slave                      in_if,
  output logic                                AUD_BCK,
  output logic                                AUD_LRCK,
  output logic                                AUD_DATA,
  output logic                                frame_start,
  output logic                                underflow,
  output logic [fifo_lvl_w(FIFO_DEPTH)-1:0]   fifo_level
);
  localparam int FRAME_W = 2 * SLOT_W;
  localparam int POS_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_HALF - 1);

  logic [2*DATA_W-1:0] fifo_rdata;
  logic                fifo_full, fifo_empty, pop;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               bck_q, bck_d;
  logic               lrck_q, lrck_d;
  logic               data_q, data_d;
  logic               fs_q, fs_d;
  logic               fmt_q, fmt_d;
  logic               uf_q, uf_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               fall;

  sync_fifo #(.WIDTH(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_if.in_valid),
    .wdata ({in_if.in_left, in_if.in_right}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign in_if.in_ready = !fifo_full;

  // Frame bit k is transmitted at slot position k: index 0 holds the left
  // MSB, index SLOT_W the right MSB; unused slot bits are zero padding.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [2*DATA_W-1:0] pair);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int k = 0; k < DATA_W; k++) begin
      f[k]          = pair[2*DATA_W-1-k];
      f[SLOT_W + k] = pair[DATA_W-1-k];
    end
    return f;
  endfunction

  always_comb begin
    div_d   = div_q;
    bck_d   = bck_q;
    pos_d   = pos_q;
    lrck_d  = lrck_q;
    data_d  = data_q;
    fs_d    = 1'b0;
    fmt_d   = fmt_q;
    frame_d = frame_q;
    uf_d    = uf_q && !clr_underflow;
    pop     = 1'b0;
    fall    = 1'b0;
    if (!en) begin
      div_d  = '0;
      bck_d  = 1'b0;
      pos_d  = POS_LAST;
      lrck_d = 1'b0;
      data_d = 1'b0;
    end else begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        bck_d = !bck_q;
        fall  = bck_q;
      end else begin
        div_d = div_q + 1'b1;
      end
      if (fall) begin
        if (pos_q == POS_LAST) begin
          // Frame load: the head entry is sampled from registered FIFO
          // state, so a push in this same cycle cannot fill an empty FIFO.
          pos_d = '0;
          fs_d  = 1'b1;
          fmt_d = fmt;
          if (fifo_empty) begin
            frame_d = '0;
            uf_d    = 1'b1;
          end else begin
            frame_d = build_frame(fifo_rdata);
            pop     = 1'b1;
          end
          // I2S slot 0 still carries the final bit of the outgoing frame.
          data_d = (fmt == FMT_LJ) ? frame_d[0] : frame_q[FRAME_W-1];
        end else begin
          pos_d  = pos_q + 1'b1;
          data_d = (fmt_q == FMT_LJ) ? frame_q[pos_d] : frame_q[pos_q];
        end
        lrck_d = (pos_d >= POS_W'(SLOT_W));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      bck_q   <= 1'b0;
      pos_q   <= POS_LAST;
      lrck_q  <= 1'b0;
      data_q  <= 1'b0;
      fs_q    <= 1'b0;
      fmt_q   <= FMT_I2S;
      uf_q    <= 1'b0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      bck_q   <= bck_d;
      pos_q   <= pos_d;
      lrck_q  <= lrck_d;
      data_q  <= data_d;
      fs_q    <= fs_d;
      fmt_q   <= fmt_d;
      uf_q    <= uf_d;
      frame_q <= frame_d;
    end
  end

  assign AUD_BCK     = bck_q;
  assign AUD_LRCK    = lrck_q;
  assign AUD_DATA    = data_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Bench for i2s_tx_stereo: one instance with default parameters and one
// with DATA_W=24, SLOT_W=32, BCK_HALF=3. Expected serial bits come from a
// slot-position model of the frame format.
module tb_i2s_tx_stereo;
  localparam int D0 = 16, S0 = 16, H0 = 6;
  localparam int D1 = 24, S1 = 32, H1 = 3;

  logic clk;
  logic reset;
  int   cyc = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance 0 (defaults) ----------------
  logic       en0, fmt0, clr0;
  logic       bck0, lrck0, data0, fs0, uf0;
  logic [2:0] lvl0;
  i2s_tx_stereo_if #(.DATA_W(D0)) if0 ();
  i2s_tx_stereo #(.DATA_W(D0), .SLOT_W(S0), .BCK_HALF(H0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .en(en0), .fmt(fmt0), .clr_underflow(clr0),
    .in_if(if0.slave), .AUD_BCK(bck0), .AUD_LRCK(lrck0), .AUD_DATA(data0),
    .frame_start(fs0), .underflow(uf0), .fifo_level(lvl0));

  // ---------------- instance 1 (24-bit / 32-slot) ----------------
  logic       en1, fmt1, clr1;
  logic       bck1, lrck1, data1, fs1, uf1;
  logic [2:0] lvl1;
  i2s_tx_stereo_if #(.DATA_W(D1)) if1 ();
  i2s_tx_stereo #(.DATA_W(D1), .SLOT_W(S1), .BCK_HALF(H1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .fmt(fmt1), .clr_underflow(clr1),
    .in_if(if1.slave), .AUD_BCK(bck1), .AUD_LRCK(lrck1), .AUD_DATA(data1),
    .frame_start(fs1), .underflow(uf1), .fifo_level(lvl1));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] sl [9];
  logic [31:0] sr [9];
  logic        sf [9];
  logic [31:0] r1;
  logic        prev;
  int          c0, last_fs, n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Bit at slot position k of a frame: left sample MSB-first in slot 0,
  // right sample MSB-first in slot 1, zero padding after DATA_W bits.
  function automatic logic frame_bit(input logic [31:0] l, input logic [31:0] r,
                                     input int dw, input int sw, input int k);
    int j;
    logic [31:0] s;
    if (k < sw) begin j = k; s = l; end
    else begin j = k - sw; s = r; end
    if (j < dw) return s[dw-1-j];
    return 1'b0;
  endfunction

  // LJ sends frame bit k at position k; I2S sends it one position later,
  // so position 0 carries the previous frame's last bit.
  function automatic logic exp_data(input logic [31:0] l, input logic [31:0] r, input logic f,
                                    input int dw, input int sw, input int k, input logic pv);
    if (f) return frame_bit(l, r, dw, sw, k);
    if (k == 0) return pv;
    return frame_bit(l, r, dw, sw, k - 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push0(input logic [31:0] l, input logic [31:0] r);
    if0.in_valid = 1'b1;
    if0.in_left  = l[15:0];
    if0.in_right = r[15:0];
    @(negedge clk);
  endtask

  task automatic wait_fs0(input int limit);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!fs0 && k < limit);
    chk("fs0_seen", {31'd0, fs0}, 32'd1);
  endtask

  // Called on the negedge where frame_start is seen; samples each bit at
  // the BCK rising edge and ends half a BCK before the next frame load.
  task automatic check_frame0(input logic [31:0] l, input logic [31:0] r,
                              input logic f, input logic pv);
    for (int p = 0; p < 2*S0; p++) begin
      if (p > 0) begin
        repeat (H0) @(negedge clk);
        chk($sformatf("bck0_fall p%0d", p), {31'd0, bck0}, 32'd0);
      end
      repeat (H0) @(negedge clk);
      chk($sformatf("bck0_rise p%0d", p), {31'd0, bck0}, 32'd1);
      chk($sformatf("lrck0 p%0d", p), {31'd0, lrck0}, {31'd0, (p >= S0)});
      chk($sformatf("data0 p%0d", p), {31'd0, data0},
          {31'd0, exp_data(l, r, f, D0, S0, p, pv)});
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    en0 = 1'b0; fmt0 = 1'b0; clr0 = 1'b0;
    en1 = 1'b0; fmt1 = 1'b0; clr1 = 1'b0;
    if0.in_valid = 1'b0; if0.in_left = '0; if0.in_right = '0;
    if1.in_valid = 1'b0; if1.in_left = '0; if1.in_right = '0;

    sl[0] = 32'hA5F0; sr[0] = 32'h0F5A; sf[0] = 1'b0;
    sl[1] = 32'hA5F0; sr[1] = 32'h0F5A; sf[1] = 1'b1;
    for (int i = 2; i < 9; i++) begin
      sl[i] = 32'($urandom_range(0, 16'hFFFF));
      sr[i] = 32'($urandom_range(0, 16'hFFFF));
      sf[i] = 1'($urandom_range(0, 1));
    end
    sl[4] = 32'h0; sr[4] = 32'h0; sf[4] = 1'b1;  // muted frame
    sf[3] = 1'b1;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_bck",   {31'd0, bck0},  32'd0);
    chk("rst_lrck",  {31'd0, lrck0}, 32'd0);
    chk("rst_data",  {31'd0, data0}, 32'd0);
    chk("rst_fs",    {31'd0, fs0},   32'd0);
    chk("rst_uf",    {31'd0, uf0},   32'd0);
    chk("rst_level", {29'd0, lvl0},  32'd0);
    chk("rst_ready", {31'd0, if0.in_ready}, 32'd1);

    // Fill the FIFO while idle, then offer a fifth pair that must stall.
    for (int i = 0; i < 4; i++) push0(sl[i], sr[i]);
    if0.in_left = 16'h1234; if0.in_right = 16'h5678;
    chk("full_ready", {31'd0, if0.in_ready}, 32'd0);
    chk("full_level", {29'd0, lvl0}, 32'd4);
    @(negedge clk);
    chk("full_level_hold", {29'd0, lvl0}, 32'd4);
    if0.in_valid = 1'b0;

    // Enable: BCK rises after BCK_HALF clocks, first load at 2*BCK_HALF.
    fmt0 = sf[0];
    en0  = 1'b1;
    c0   = cyc;
    repeat (H0 - 1) @(negedge clk);
    chk("bck_first_low", {31'd0, bck0}, 32'd0);
    @(negedge clk);
    chk("bck_first_rise", {31'd0, bck0}, 32'd1);
    wait_fs0(20);
    chk("first_load_delay", cyc - c0, 32'(2*H0));
    last_fs = cyc;
    prev = 1'b0;

    for (int f = 0; f < 6; f++) begin
      if (f > 0) begin
        fmt0 = sf[f];
        wait_fs0(20);
        chk($sformatf("lrck_period f%0d", f), cyc - last_fs, 32'(2*S0*2*H0));
        last_fs = cyc;
      end
      chk($sformatf("fs_level f%0d", f), {29'd0, lvl0}, (f < 4) ? 32'(3 - f) : 32'd0);
      chk($sformatf("fs_ready f%0d", f), {31'd0, if0.in_ready}, 32'd1);
      chk($sformatf("fs_uf f%0d", f), {31'd0, uf0}, {31'd0, (f == 4)});
      check_frame0(sl[f], sr[f], sf[f], prev);
      prev = frame_bit(sl[f], sr[f], D0, S0, 2*S0 - 1);
      if (f == 4) begin
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        chk("uf_cleared", {31'd0, uf0}, 32'd0);
        push0(sl[5], sr[5]);
        if0.in_valid = 1'b0;
        chk("refill_level", {29'd0, lvl0}, 32'd1);
      end
    end

    // Drop en in the right slot: outputs idle next cycle, FIFO kept.
    en0 = 1'b0;
    @(negedge clk);
    chk("en_off_bck",  {31'd0, bck0},  32'd0);
    chk("en_off_lrck", {31'd0, lrck0}, 32'd0);
    chk("en_off_data", {31'd0, data0}, 32'd0);
    push0(sl[6], sr[6]);
    if0.in_valid = 1'b0;
    chk("en_off_push", {29'd0, lvl0}, 32'd1);
    fmt0 = 1'b1;
    en0  = 1'b1;
    c0   = cyc;
    wait_fs0(30);
    chk("reenable_delay", cyc - c0, 32'(2*H0));
    last_fs = cyc;
    chk("reenable_level", {29'd0, lvl0}, 32'd0);
    check_frame0(sl[6], sr[6], 1'b1, prev);

    // Leave one entry in the FIFO, then reset in the right slot.
    push0(sl[7], sr[7]);
    push0(sl[8], sr[8]);
    if0.in_valid = 1'b0;
    wait_fs0(20);
    chk("pre_rst_period", cyc - last_fs, 32'(2*S0*2*H0));
    chk("pre_rst_level", {29'd0, lvl0}, 32'd1);
    repeat (20 * 2 * H0) @(negedge clk);
    chk("pre_rst_lrck", {31'd0, lrck0}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_bck",   {31'd0, bck0},  32'd0);
    chk("mid_rst_lrck",  {31'd0, lrck0}, 32'd0);
    chk("mid_rst_data",  {31'd0, data0}, 32'd0);
    chk("mid_rst_fs",    {31'd0, fs0},   32'd0);
    chk("mid_rst_level", {29'd0, lvl0},  32'd0);
    chk("mid_rst_ready", {31'd0, if0.in_ready}, 32'd1);
    reset = 1'b0;
    fmt0  = 1'b0;
    c0    = cyc;
    wait_fs0(30);
    chk("post_rst_delay", cyc - c0, 32'(2*H0));
    chk("post_rst_uf", {31'd0, uf0}, 32'd1);
    check_frame0(32'd0, 32'd0, 1'b0, 1'b0);

    // Instance 1: 24-bit samples in 32-bit slots, LJ, BCK = clk/6.
    r1 = 32'($urandom_range(0, 24'hFFFFFF));
    fmt1 = 1'b1;
    if1.in_valid = 1'b1;
    if1.in_left  = 24'h800001;
    if1.in_right = r1[23:0];
    @(negedge clk);
    if1.in_valid = 1'b0;
    chk("d1_level", {29'd0, lvl1}, 32'd1);
    en1 = 1'b1;
    c0  = cyc;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs1 && n < 40);
    chk("d1_fs_seen", {31'd0, fs1}, 32'd1);
    chk("d1_first_load", cyc - c0, 32'(2*H1));
    for (int p = 0; p < 2*S1; p++) begin
      if (p > 0) begin
        repeat (H1) @(negedge clk);
        chk($sformatf("d1_bck_fall p%0d", p), {31'd0, bck1}, 32'd0);
      end
      repeat (H1) @(negedge clk);
      chk($sformatf("d1_bck_rise p%0d", p), {31'd0, bck1}, 32'd1);
      chk($sformatf("d1_lrck p%0d", p), {31'd0, lrck1}, {31'd0, (p >= S1)});
      chk($sformatf("d1_data p%0d", p), {31'd0, data1},
          {31'd0, exp_data(32'h800001, r1, 1'b1, D1, S1, p, 1'b0)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
